// File: rtl/intersection_scheduler.sv
// Two-direction intersection light controller: Moore FSM with sticky requests and a pass override.
// Define ALLRED_CLEAR_EN to insert all-red clearance phases between yellow and the opposite green.
module intersection_scheduler #(
    parameter int GREEN_MIN = 64,
    parameter int GREEN_MAX = 512,
    parameter int YELLOW_T  = 256,
    parameter int ALLRED_T  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       pass,
    input  logic       pass_dir,
    output logic       ra,
    output logic       ya,
    output logic       ga,
    output logic       rb,
    output logic       yb,
    output logic       gb,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        CLR_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        CLR_BA = 3'd5,
        ILL_6  = 3'd6,
        ILL_7  = 3'd7
    } state_t;

`ifdef ALLRED_CLEAR_EN
    localparam logic CLR_EN = 1'b1;
`else
    localparam logic CLR_EN = 1'b0;
`endif

    localparam logic [9:0] GMIN_LIM   = 10'(GREEN_MIN - 1);
    localparam logic [9:0] GMAX_LIM   = 10'(GREEN_MAX - 1);
    localparam logic [9:0] YEL_LIM    = 10'(YELLOW_T - 1);
    localparam logic [9:0] ALLRED_LIM = 10'(ALLRED_T - 1);

    // Lamp pattern {ra, ya, ga, rb, yb, gb}; anything that is not a green or yellow is all red.
    function automatic logic [5:0] lamp_decode(input state_t s);
        logic [5:0] l;
        case (s)
            A_GRN:   l = 6'b001_100;
            A_YEL:   l = 6'b010_100;
            B_GRN:   l = 6'b100_001;
            B_YEL:   l = 6'b100_010;
            default: l = 6'b100_100;
        endcase
        return l;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [9:0]  cnt_r;
    logic [9:0]  cnt_nxt_s;
    logic        hold_s;
    logic        green_s;
    logic        pend_a_r;
    logic        pend_b_r;
    logic        pend_a_nxt_s;
    logic        pend_b_nxt_s;
    logic [5:0]  lamp_r;

    // Next-state selection; hold_s marks a pass-held green whose counter must not advance.
    always_comb begin
        state_nxt_s = A_GRN;
        hold_s      = 1'b0;
        case (state_r)
            A_GRN: begin
                if (pass == 1'b1 && pass_dir == 1'b0) begin
                    state_nxt_s = A_GRN;
                    hold_s      = 1'b1;
                end else if (pass == 1'b1) begin
                    state_nxt_s = A_YEL;
                end else if (pend_b_r == 1'b1 && cnt_r >= GMIN_LIM) begin
                    state_nxt_s = A_YEL;
                end else begin
                    state_nxt_s = A_GRN;
                end
            end
            A_YEL: begin
                if (cnt_r == YEL_LIM) begin
                    state_nxt_s = CLR_EN ? CLR_AB : B_GRN;
                end else begin
                    state_nxt_s = A_YEL;
                end
            end
            CLR_AB: begin
                if (CLR_EN == 1'b0) begin
                    state_nxt_s = A_GRN;
                end else if (cnt_r == ALLRED_LIM) begin
                    state_nxt_s = B_GRN;
                end else begin
                    state_nxt_s = CLR_AB;
                end
            end
            B_GRN: begin
                if (pass == 1'b1 && pass_dir == 1'b1) begin
                    state_nxt_s = B_GRN;
                    hold_s      = 1'b1;
                end else if (pass == 1'b1) begin
                    state_nxt_s = B_YEL;
                end else if (pend_a_r == 1'b1 && cnt_r >= GMIN_LIM) begin
                    state_nxt_s = B_YEL;
                end else begin
                    state_nxt_s = B_GRN;
                end
            end
            B_YEL: begin
                if (cnt_r == YEL_LIM) begin
                    state_nxt_s = CLR_EN ? CLR_BA : A_GRN;
                end else begin
                    state_nxt_s = B_YEL;
                end
            end
            CLR_BA: begin
                if (CLR_EN == 1'b0) begin
                    state_nxt_s = A_GRN;
                end else if (cnt_r == ALLRED_LIM) begin
                    state_nxt_s = A_GRN;
                end else begin
                    state_nxt_s = CLR_BA;
                end
            end
            default: begin
                state_nxt_s = A_GRN;
                hold_s      = 1'b0;
            end
        endcase
    end

    // Phase counter: cleared on any state change, frozen under pass hold, saturating in green.
    always_comb begin
        cnt_nxt_s = cnt_r;
        green_s   = (state_r == A_GRN) || (state_r == B_GRN);
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = 10'd0;
        end else if (hold_s == 1'b1) begin
            cnt_nxt_s = cnt_r;
        end else if (green_s == 1'b1 && cnt_r >= GMAX_LIM) begin
            cnt_nxt_s = GMAX_LIM;
        end else begin
            cnt_nxt_s = cnt_r + 10'd1;
        end
    end

    // Sticky requests; a request on the entry edge wins over the entry clear.
    always_comb begin
        pend_a_nxt_s = pend_a_r;
        pend_b_nxt_s = pend_b_r;
        if (req_a == 1'b1) begin
            pend_a_nxt_s = 1'b1;
        end else if (state_nxt_s == A_GRN && state_r != A_GRN) begin
            pend_a_nxt_s = 1'b0;
        end else begin
            pend_a_nxt_s = pend_a_r;
        end
        if (req_b == 1'b1) begin
            pend_b_nxt_s = 1'b1;
        end else if (state_nxt_s == B_GRN && state_r != B_GRN) begin
            pend_b_nxt_s = 1'b0;
        end else begin
            pend_b_nxt_s = pend_b_r;
        end
    end

    // State, counter, request flags and lamp registers; lamps load the decode of the next state
    // so they switch on the same edge as the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= A_GRN;
            cnt_r    <= 10'd0;
            pend_a_r <= 1'b0;
            pend_b_r <= 1'b0;
            lamp_r   <= 6'b001_100;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            pend_a_r <= pend_a_nxt_s;
            pend_b_r <= pend_b_nxt_s;
            lamp_r   <= lamp_decode(state_nxt_s);
        end
    end

    assign {ra, ya, ga, rb, yb, gb} = lamp_r;
    assign phase                    = state_r;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: stimulus queues expected phase changes with their
// cycle stamps; a negedge monitor pops and compares them, and checks lamps every cycle.
module tb_intersection_scheduler;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       req_a    = 1'b0;
    logic       req_b    = 1'b0;
    logic       pass     = 1'b0;
    logic       pass_dir = 1'b0;
    logic       ra, ya, ga, rb, yb, gb;
    logic [2:0] phase;

`ifdef ALLRED_CLEAR_EN
    localparam int  CLR     = 64;
    localparam bit  HAS_CLR = 1'b1;
`else
    localparam int  CLR     = 0;
    localparam bit  HAS_CLR = 1'b0;
`endif
    localparam int YEL = 256;

    typedef struct {
        logic [2:0] ph;
        int         at;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] last_ph = 3'd0;

    intersection_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .pass     (pass),
        .pass_dir (pass_dir),
        .ra       (ra),
        .ya       (ya),
        .ga       (ga),
        .rb       (rb),
        .yb       (yb),
        .gb       (gb),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    // Cycle stamp: after the k-th rising edge following reset release, cyc == k.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic logic [5:0] exp_lamps(input logic [2:0] ph);
        case (ph)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every phase change must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            last_ph = 3'd0;
        end else begin
            if (phase !== last_ph) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got phase %0d at cycle %0d required phase %0d",
                             phase, cyc, last_ph);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("transition_phase", int'(phase), int'(mon_e.ph));
                    chk("transition_cycle", cyc, mon_e.at);
                end
                last_ph = phase;
            end
            chk("lamps", int'({ra, ya, ga, rb, yb, gb}), int'(exp_lamps(phase)));
        end
    end

    task automatic push(input logic [2:0] ph, input int at);
        exp_t e;
        e.ph = ph;
        e.at = at;
        exp_q.push_back(e);
    endtask

    // Queue a full yield from one direction starting at cycle t; g returns the new green cycle.
    task automatic push_yield(input bit from_b, input int t, output int g);
        push(from_b ? 3'd4 : 3'd1, t);
        if (HAS_CLR) push(from_b ? 3'd5 : 3'd2, t + YEL);
        g = t + YEL + CLR;
        push(from_b ? 3'd0 : 3'd3, g);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse(input bit a, input bit b);
        req_a = a;
        req_b = b;
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    // Asynchronous reset: outputs must settle before any clock edge, then release.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("reset_lamps", int'({ra, ya, ga, rb, yb, gb}), int'(6'b001_100));
        chk("reset_phase", int'(phase), 0);
        exp_q.delete();
        pass     = 1'b0;
        pass_dir = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    int bg, ag, bg2, ag2, aa, bg3, aa3;

    initial begin
        // Long idle green, then a request after the counter has saturated.
        do_reset();
        wait_cyc(2048);
        push_yield(1'b0, 2050, bg);
        pulse(1'b0, 1'b1);
        wait_cyc(bg + 200);
        chk("drained_idle", exp_q.size(), 0);

        // Request B, then pass toward A mid B-green, pass hold, pass toward B, freeze check.
        wait_cyc(cyc + 1);
        do_reset();
        push_yield(1'b0, 64, bg);
        wait_cyc(10);
        pulse(1'b0, 1'b1);
        wait_cyc(bg + 5);
        push_yield(1'b1, bg + 6, ag);
        pass     = 1'b1;
        pass_dir = 1'b0;
        wait_cyc(ag + 10);
        pulse(1'b0, 1'b1);
        wait_cyc(ag + 100);
        push_yield(1'b0, ag + 101, bg2);
        pass_dir = 1'b1;
        wait_cyc(bg2 + 50);
        pass     = 1'b0;
        pass_dir = 1'b0;
        wait_cyc(bg2 + 60);
        push_yield(1'b1, bg2 + 114, ag2);
        pulse(1'b1, 1'b0);
        wait_cyc(ag2 + 300);
        chk("drained_pass", exp_q.size(), 0);

        // Simultaneous requests alternate; a request on the entry edge of its green is kept.
        do_reset();
        push_yield(1'b0, 64, bg);
        push_yield(1'b1, bg + 64, aa);
        wait_cyc(5);
        pulse(1'b1, 1'b1);
        wait_cyc(aa - 1);
        pulse(1'b1, 1'b0);
        wait_cyc(aa + 100);
        push_yield(1'b0, aa + 102, bg3);
        push_yield(1'b1, bg3 + 64, aa3);
        pulse(1'b0, 1'b1);
        wait_cyc(aa3 + 200);
        chk("drained_alternate", exp_q.size(), 0);

        // Reset dropped mid-yellow.
        do_reset();
        push(3'd1, 64);
        wait_cyc(10);
        pulse(1'b0, 1'b1);
        wait_cyc(164);
        chk("pre_reset_phase", int'(phase), 1);
        do_reset();
        wait_cyc(300);
        chk("drained_after_reset", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 The block SHALL have parameter GREEN_MIN, default 64: minimum green cycles before yielding to a pending opposite request.
REQ-002 The block SHALL have parameter GREEN_MAX, default 512: green cycles after which a pending opposite request forces yield.
REQ-003 The block SHALL have parameter YELLOW_T, default 256: yellow duration in cycles.
REQ-004 The block SHALL have parameter ALLRED_T, default 64: all-red clearance duration in cycles; all parameters are legal in 1..1023 with GREEN_MIN <= GREEN_MAX.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req_a, req_b  input  1 each  vehicle/pedestrian request for direction A or B; a one-cycle pulse suffices.
REQ-008 pass  input  1  emergency override, level-sensitive.
REQ-009 pass_dir  input  1  direction favoured by pass (0 = A, 1 = B); sampled only while pass = 1.
REQ-010 ra, ya, ga, rb, yb, gb  output  1 each  lamp drives for A and B.
REQ-011 phase  output  3  current state code (encodings per REQ-013).

Function
REQ-012 The block SHALL be a Moore FSM with a 10-bit cycle counter; lamps and phase SHALL decode from the state register only, so they change on the same edge as the state.
REQ-013 States SHALL be: A_GRN=0, A_YEL=1, CLR_AB=2, B_GRN=3, B_YEL=4, CLR_BA=5; codes 6-7 SHALL decode to all lamps red and return to A_GRN on the next edge.
REQ-014 Lamps SHALL be: X_GRN gives that direction green and the other red; X_YEL gives that direction yellow and the other red; CLR_* gives both red; each direction SHALL have exactly one lamp on at all times.
REQ-015 Sticky flags pend_a/pend_b SHALL be set on req_a/req_b and cleared on entry to that direction's green; a request arriving on the entry edge SHALL be kept.
REQ-016 The counter SHALL clear on every state change and increment otherwise; in green states it SHALL saturate at GREEN_MAX-1.
REQ-017 In X_GRN with pass = 0, the block SHALL move to X_YEL when the opposite flag is set and counter >= GREEN_MIN-1; with the opposite flag clear it SHALL stay green indefinitely.
REQ-018 In X_YEL the block SHALL move on the edge where counter == YELLOW_T-1; in CLR_XY it SHALL move to Y_GRN on the edge where counter == ALLRED_T-1.
REQ-019 With pass = 1 and pass_dir selecting the current green direction, the block SHALL hold green regardless of requests, with the counter frozen.
REQ-020 With pass = 1 and pass_dir selecting the other direction during green, the block SHALL enter X_YEL on the next edge regardless of GREEN_MIN.
REQ-021 Yellow and clearance phases SHALL always run to completion; pass SHALL NOT shorten or extend them.
REQ-022 When req_a and req_b arrive on the same edge, the current green direction SHALL yield (its own flag clears on its next entry), so service alternates.

Reset
REQ-023 Asserting rst low SHALL immediately force state A_GRN, counter 0, pend_a = pend_b = 0, hence ga = 1, rb = 1, all other lamps 0, phase = 0, including mid-yellow or mid-clearance.
REQ-024 After rst deasserts, counting SHALL start on the first rising clk edge.

Configuration
REQ-025 With macro ALLRED_CLEAR_EN defined, CLR_AB and CLR_BA SHALL be used per REQ-018.
REQ-026 Without ALLRED_CLEAR_EN, X_YEL SHALL go directly to Y_GRN on counter == YELLOW_T-1, and codes 2 and 5 SHALL be treated as illegal per REQ-013.

Verification
REQ-027 Reset, no requests for 2000 cycles -> ga = 1, rb = 1 throughout, phase = 0.
REQ-028 Pulse req_b at cycle 10 -> A_YEL entered when counter reaches 63, i.e. 64 cycles after reset; CLR_AB after 256 more cycles; B_GRN after 64 more cycles, with pend_b cleared.
REQ-029 In B_GRN at counter 5, assert pass = 1, pass_dir = 0 -> B_YEL on next edge; then 256 yellow + 64 clear cycles -> A_GRN.
REQ-030 Pulse req_a and req_b together in A_GRN -> sequence A->B after minimum green, then B->A after GREEN_MIN in B_GRN.
REQ-031 Drop rst low at counter 100 of A_YEL -> outputs return to ga = 1, rb = 1 asynchronously, before the next clk edge.
REQ-032 Build without ALLRED_CLEAR_EN, pulse req_b -> A_YEL goes directly to B_GRN after 256 cycles, and phase never equals 2.
